// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared state encoding and constants
// for the byte transmit sequencer.
package usb_tx_pkg;

    localparam int CLKS_PER_BIT_DEF = 8;
    localparam int MAX_BYTES_DEF    = 64;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_DONE,
        ST_ERROR
    } tx_state_e;

endpackage

// File: rtl/byte_tx_sequencer_if.sv
// byte_tx_sequencer_if: packet request, FIFO and
// byte register control bundle.
interface byte_tx_sequencer_if;

    logic       tx_start;
    logic [7:0] pid;
    logic [6:0] byte_count;
    logic       abort;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [7:0] fsm_byte;
    logic       load_en;
    logic       select;
    logic       shift_en;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_start, pid, byte_count,
        output abort, fifo_empty,
        input  fifo_pop, fsm_byte, load_en,
        input  select, shift_en,
        input  tx_busy, tx_done, tx_error
    );

    modport slave (
        input  tx_start, pid, byte_count,
        input  abort, fifo_empty,
        output fifo_pop, fsm_byte, load_en,
        output select, shift_en,
        output tx_busy, tx_done, tx_error
    );

endinterface

// File: rtl/byte_tx_sequencer_bit_timer.sv
// bit_timer: clock divider and 3-bit bit counter
// pacing the eight shifts of one byte slot.
module bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic restart,
    output logic shift_en,
    output logic byte_end
);

    localparam int DW = $clog2(CLKS_PER_BIT);
    localparam logic [DW-1:0] LAST = DW'(CLKS_PER_BIT - 1);

    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic          active_q;

    // The load cycle is slot cycle 0, so the divider resumes at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
        end else if (clr) begin
            div_q    <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
        end else if (restart) begin
            div_q    <= DW'(1);
            bit_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (div_q == LAST) begin
                div_q    <= '0;
                bit_q    <= bit_q + 3'd1;
                active_q <= (bit_q != 3'd7);
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

    assign shift_en = active_q && (div_q == LAST);
    assign byte_end = shift_en && (bit_q == 3'd7);

endmodule

// File: rtl/byte_tx_sequencer.sv
// byte_tx_sequencer: emits SYNC, PID and FIFO data
// bytes into a serial byte register.
module byte_tx_sequencer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int MAX_BYTES    = MAX_BYTES_DEF
) (
    input logic clk,
    input logic rst,
    byte_tx_sequencer_if.slave bus
);

    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    tx_state_e  state_q, state_d;
    logic       first_q, first_d;
    logic [7:0] pid_q, pid_d;
    logic [6:0] cnt_q, cnt_d;
    logic       cancel;
    logic       load;
    logic       pop;
    logic       tmr_shift;
    logic       byte_end;

    assign cancel = bus.abort && (state_q != ST_IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (cancel),
        .restart  (load),
        .shift_en (tmr_shift),
        .byte_end (byte_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
            pid_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            pid_q   <= pid_d;
            cnt_q   <= cnt_d;
        end
    end

    // first_q marks slot cycle 0 of the byte state just entered.
    always_comb begin
        state_d = state_q;
        first_d = 1'b0;
        pid_d   = pid_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        pop     = 1'b0;
        if (cancel) begin
            state_d = ST_ERROR;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.tx_start) begin
                        state_d = ST_SYNC;
                        first_d = 1'b1;
                        pid_d   = bus.pid;
                        cnt_d   = (bus.byte_count > MAX_CNT) ?
                                  MAX_CNT : bus.byte_count;
                    end
                end
                ST_SYNC: begin
                    load = first_q;
                    if (byte_end) begin
                        state_d = ST_PID;
                        first_d = 1'b1;
                    end
                end
                ST_PID: begin
                    load = first_q;
                    if (byte_end) begin
                        state_d = (cnt_q != '0) ? ST_DATA : ST_DONE;
                        first_d = (cnt_q != '0);
                    end
                end
                ST_DATA: begin
                    if (first_q) begin
                        if (bus.fifo_empty) begin
                            state_d = ST_ERROR;
                        end else begin
                            load  = 1'b1;
                            pop   = 1'b1;
                            cnt_d = cnt_q - 7'd1;
                        end
                    end else if (byte_end) begin
                        state_d = (cnt_q != '0) ? ST_DATA : ST_DONE;
                        first_d = (cnt_q != '0);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.load_en  = load;
    assign bus.fifo_pop = pop;
    assign bus.select   = (state_q == ST_DATA);
    assign bus.shift_en = tmr_shift && !cancel;
    assign bus.tx_busy  = (state_q != ST_IDLE);
    assign bus.tx_done  = (state_q == ST_DONE);
    assign bus.tx_error = (state_q == ST_ERROR);
    assign bus.fsm_byte = (state_q == ST_SYNC) ? SYNC_BYTE :
                          (state_q == ST_PID)  ? pid_q : 8'h00;

endmodule

// File: tb/tb_byte_tx_sequencer.sv
// tb_byte_tx_sequencer: directed packets checked against a
// slot-arithmetic reference model plus literal timing points.
module tb_byte_tx_sequencer;

    localparam int C1 = 8;
    localparam int S1 = 8 * C1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   t0 = 0;
    int   total = 0;
    int   bad = 0;
    int   pops = 0;
    int   p0 = 0;

    byte_tx_sequencer_if bus ();
    byte_tx_sequencer_if bus2 ();

    byte_tx_sequencer #(
        .CLKS_PER_BIT(C1),
        .MAX_BYTES(64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    byte_tx_sequencer #(
        .CLKS_PER_BIT(4),
        .MAX_BYTES(64)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [14:0] o1, o2;
    assign o1 = {bus.load_en, bus.fifo_pop, bus.select,
                 bus.shift_en, bus.tx_busy, bus.tx_done,
                 bus.tx_error, bus.fsm_byte};
    assign o2 = {bus2.load_en, bus2.fifo_pop, bus2.select,
                 bus2.shift_en, bus2.tx_busy, bus2.tx_done,
                 bus2.tx_error, bus2.fsm_byte};

    task automatic chk(input string nm, input int act,
                       input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: position in the packet from elapsed cycles.
    int md = 0;
    int tf = 0;
    int nb = 0;
    logic [7:0] mpid = 8'h00;

    always @(negedge clk) begin : model
        int e, slot, off;
        logic starve;
        logic [14:0] ev;
        ev = '0;
        starve = 1'b0;
        if (rst) begin
            md = 0;
        end else begin
            case (md)
                0: begin
                    if (bus.tx_start) begin
                        md = 1;
                        tf = cyc + 1;
                        mpid = bus.pid;
                        nb = (bus.byte_count > 64) ?
                             64 : int'(bus.byte_count);
                    end
                end
                1: begin
                    e = cyc - tf;
                    slot = e / S1;
                    off = e % S1;
                    ev[10] = 1'b1;
                    ev[12] = (slot >= 2);
                    ev[7:0] = (slot == 0) ? 8'h80 :
                              (slot == 1) ? mpid : 8'h00;
                    starve = (slot >= 2) && (off == 0) &&
                             bus.fifo_empty;
                    ev[14] = (off == 0) && !bus.abort && !starve;
                    ev[13] = ev[14] && (slot >= 2);
                    ev[11] = (off != 0) && ((off + 1) % C1 == 0) &&
                             !bus.abort;
                    if (bus.abort || starve)
                        md = 3;
                    else if (off == S1 - 1 && slot == nb + 1)
                        md = 2;
                end
                2: begin
                    ev[10] = 1'b1;
                    ev[9] = 1'b1;
                    md = bus.abort ? 3 : 0;
                end
                default: begin
                    ev[10] = 1'b1;
                    ev[8] = 1'b1;
                    md = bus.abort ? 3 : 0;
                end
            endcase
        end
        total++;
        if (o1 !== ev) begin
            bad++;
            $display("FAIL model@%0d: got %h want %h", cyc, o1, ev);
        end
        if (bus.fifo_pop) pops++;
    end

    logic rec2 = 1'b0;
    int   l2[$];
    int   s2[$];
    int   d2 = -1;

    always @(negedge clk) begin
        if (rec2) begin
            if (bus2.load_en) l2.push_back(cyc - t0);
            if (bus2.shift_en) s2.push_back(cyc - t0);
            if (bus2.tx_done) d2 = cyc - t0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int rel);
        while (cyc < t0 + rel) step();
    endtask

    task automatic at(input int rel);
        go(rel);
        #5;
    endtask

    task automatic start(input logic [7:0] p, input logic [6:0] n);
        step();
        t0 = cyc;
        bus.pid = p;
        bus.byte_count = n;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
    endtask

    initial begin
        bus.tx_start = 1'b0;
        bus.pid = 8'h00;
        bus.byte_count = 7'd0;
        bus.abort = 1'b0;
        bus.fifo_empty = 1'b0;
        bus2.tx_start = 1'b0;
        bus2.pid = 8'h00;
        bus2.byte_count = 7'd0;
        bus2.abort = 1'b0;
        bus2.fifo_empty = 1'b0;

        repeat (3) step();
        #5;
        chk("reset_outs", int'(o1), 0);
        chk("reset_outs2", int'(o2), 0);
        rst = 1'b0;
        repeat (2) step();

        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        step();
        #5;
        chk("idle_abort_busy", int'(bus.tx_busy), 0);

        // one data byte
        start(8'hC3, 7'd1);
        at(1);
        chk("p1_sync_load", int'(bus.load_en), 1);
        chk("p1_sync_byte", int'(bus.fsm_byte), 'h80);
        at(65);
        chk("p1_pid_load", int'(bus.load_en), 1);
        chk("p1_pid_byte", int'(bus.fsm_byte), 'hC3);
        at(129);
        chk("p1_data_lps", int'({bus.load_en, bus.fifo_pop,
                                 bus.select}), 7);
        at(193);
        chk("p1_done", int'(bus.tx_done), 1);
        at(194);
        chk("p1_idle", int'(bus.tx_busy), 0);

        // zero data bytes
        p0 = pops;
        start(8'h5A, 7'd0);
        at(65);
        chk("p2_pid_byte", int'(bus.fsm_byte), 'h5A);
        at(129);
        chk("p2_done", int'(bus.tx_done), 1);
        at(130);
        chk("p2_idle", int'(bus.tx_busy), 0);
        chk("p2_pops", pops - p0, 0);

        // FIFO runs dry before the third data byte
        p0 = pops;
        start(8'h96, 7'd3);
        go(200);
        bus.fifo_empty = 1'b1;
        at(257);
        chk("p3_no_load", int'(bus.load_en), 0);
        at(258);
        chk("p3_error", int'(bus.tx_error), 1);
        at(259);
        chk("p3_idle", int'(bus.tx_busy), 0);
        chk("p3_pops", pops - p0, 2);
        bus.fifo_empty = 1'b0;

        // abort in PID, plus an ignored restart while busy
        start(8'hE1, 7'd2);
        go(50);
        bus.pid = 8'h11;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
        at(65);
        chk("p4_pid_kept", int'(bus.fsm_byte), 'hE1);
        go(100);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        #5;
        chk("p4_error", int'(bus.tx_error), 1);
        at(102);
        chk("p4_idle", int'(bus.tx_busy), 0);

        // asynchronous reset in the middle of DATA
        start(8'h4B, 7'd2);
        at(150);
        chk("p5_busy", int'(bus.tx_busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("p5_rst_outs", int'(o1), 0);
        step();
        step();
        rst = 1'b0;
        repeat (5) step();
        #5;
        chk("p5_after", int'(o1), 0);

        // oversized count clamps to 64 bytes
        p0 = pops;
        start(8'hA5, 7'd100);
        at(4225);
        chk("p6_done", int'(bus.tx_done), 1);
        at(4226);
        chk("p6_idle", int'(bus.tx_busy), 0);
        chk("p6_pops", pops - p0, 64);

        // four clocks per bit
        step();
        t0 = cyc;
        bus2.pid = 8'h3C;
        bus2.byte_count = 7'd1;
        bus2.tx_start = 1'b1;
        rec2 = 1'b1;
        step();
        bus2.tx_start = 1'b0;
        go(110);
        rec2 = 1'b0;
        chk("c4_loads", l2.size(), 3);
        for (int i = 0; i < l2.size() && i < 3; i++)
            chk("c4_load_at", l2[i], 1 + 32 * i);
        chk("c4_shifts", s2.size(), 24);
        for (int i = 0; i < s2.size(); i++)
            chk("c4_shift_at", s2[i], 32 * (i / 8) + 4 * (i % 8 + 1));
        chk("c4_done", d2, 97);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_tx_sequencer.md
BYTE_TX_SEQUENCER -- requirements
Module: byte_tx_sequencer

Interface
REQ-001 Parameter: CLKS_PER_BIT, 8, clocks per serial bit period (96 MHz / 12 Mbps); SHALL be at least 2.
REQ-002 Parameter: MAX_BYTES, 64, maximum data bytes per packet.
REQ-003 Port: clk  in  1  system clock (96 MHz), rising-edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: tx_start  in  1  one-cycle packet request; sampled only in IDLE.
REQ-006 Port: pid  in  8  PID byte; latched on accepted tx_start.
REQ-007 Port: byte_count  in  7  data bytes to send, 0..MAX_BYTES; latched on accepted tx_start.
REQ-008 Port: abort  in  1  synchronous cancel of the current packet.
REQ-009 Port: fifo_empty  in  1  data FIFO has no byte available.
REQ-010 Port: fifo_pop  out  1  one-cycle FIFO read strobe.
REQ-011 Port: fsm_byte  out  8  byte offered to the byte register FSM input.
REQ-012 Port: load_en  out  1  one-cycle parallel-load strobe to the byte register.
REQ-013 Port: select  out  1  byte register source: 0 = fsm_byte, 1 = FIFO byte.
REQ-014 Port: shift_en  out  1  one-cycle shift strobe to the byte register.
REQ-015 Port: tx_busy  out  1  high in every state except IDLE.
REQ-016 Port: tx_done  out  1  one-cycle pulse on normal completion.
REQ-017 Port: tx_error  out  1  one-cycle pulse on underrun or abort.

Function
REQ-018 States SHALL be IDLE, SYNC, PID, DATA, DONE, ERROR.
REQ-019 IDLE + tx_start SHALL go to SYNC; tx_start outside IDLE SHALL be ignored.
REQ-020 On the first cycle of each byte slot, load_en SHALL be high for exactly one cycle: SYNC -> fsm_byte=8'h80, select=0; PID -> fsm_byte=latched pid, select=0; DATA -> select=1 and fifo_pop=1 in the same cycle.
REQ-021 Within a byte slot (cycle 0 = load cycle), shift_en SHALL pulse at slot cycles k*CLKS_PER_BIT-1 for k=1..8; each slot SHALL last exactly 8*CLKS_PER_BIT cycles with no gap before the next load.
REQ-022 After the 8th shift_en: SYNC->PID; PID->DATA if latched count>0, else DONE; DATA->DATA while bytes remain, else DONE.
REQ-023 The data-byte counter SHALL decrement on each DATA load; values >MAX_BYTES SHALL be clamped to MAX_BYTES at latch.
REQ-024 If fifo_empty is high in the cycle a DATA load is due, the block SHALL assert neither load_en nor fifo_pop and SHALL go to ERROR.
REQ-025 abort high in any non-IDLE state SHALL go to ERROR on the next edge; abort in IDLE SHALL be ignored; abort SHALL take priority over a simultaneous load or state advance.
REQ-026 DONE SHALL assert tx_done for one cycle; ERROR SHALL assert tx_error for one cycle; both SHALL return to IDLE next cycle.
REQ-027 fsm_byte SHALL hold 8'h00 when not in SYNC or PID.
REQ-028 load_en, shift_en and fifo_pop SHALL never be high in the same cycle except load_en with fifo_pop.

Reset
REQ-029 rst SHALL force IDLE, all counters 0, and all outputs to 0 (fsm_byte=8'h00) immediately, including mid-packet; no tx_done or tx_error SHALL be emitted for a reset-cancelled packet.

Structure
REQ-030 A package usb_tx_pkg SHALL hold the state enum, SYNC_BYTE=8'h80 and the default CLKS_PER_BIT/MAX_BYTES constants.
REQ-031 One sub-module, bit_timer, SHALL contain the clock divider and 3-bit bit counter, producing shift_en and a byte_end strobe, restarted by load_en.

Verification
REQ-032 tx_start at cycle 0, pid=8'hC3, byte_count=1, fifo non-empty -> SYNC load at 1 (fsm_byte 80), PID load at 65 (C3), DATA load+pop at 129, tx_done at 193, IDLE at 194.
REQ-033 byte_count=0 -> two loads only, tx_done at cycle 129, fifo_pop never asserted.
REQ-034 byte_count=3, fifo_empty raised before the third DATA load -> two pops, no third load, tx_error one cycle, then IDLE.
REQ-035 abort at cycle 100 during PID -> tx_error at 101, IDLE at 102, no further load/shift strobes.
REQ-036 rst asserted mid-DATA -> all outputs 0 asynchronously, no tx_done/tx_error; second tx_start during busy ignored.
REQ-037 Count shift_en per byte slot = 8 with spacing CLKS_PER_BIT, checked also with CLKS_PER_BIT=4.
